div_by_five_arbiter: RTL and testbench
======================================

DIV_BY_FIVE_ARBITER -- requirements
Module: div_by_five_arbiter

Interface
REQ-001 SHALL have parameter NBITS, default 8, data width of all message ports.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_val / req1_val  input  1  requester N has an operand.
REQ-005 SHALL have ports req0_rdy / req1_rdy  output  1  operand from requester N accepted this cycle.
REQ-006 SHALL have ports req0_msg / req1_msg  input  NBITS  operand from requester N.
REQ-007 SHALL have ports resp0_val / resp1_val  output  1  result for requester N is valid.
REQ-008 SHALL have ports resp0_rdy / resp1_rdy  input  1  requester N takes the result.
REQ-009 SHALL have ports resp0_msg / resp1_msg  output  NBITS  result for requester N.
REQ-010 SHALL have port unit_in_val  output  1  operand offered to the shared divide-by-five unit.
REQ-011 SHALL have port unit_in_rdy  input  1  the unit can accept an operand.
REQ-012 SHALL have port unit_in_msg  output  NBITS  operand to the unit.
REQ-013 SHALL have port unit_out_val  input  1  one-cycle pulse: unit result valid; the unit takes no backpressure.
REQ-014 SHALL have port unit_out_msg  input  NBITS  unit result.
REQ-015 SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-017 SHALL, in IDLE with unit_in_rdy=1 and at least one reqN_val=1, grant exactly one requester combinationally in that cycle: reqN_rdy=1, unit_in_val=1, unit_in_msg=reqN_msg.
REQ-018 SHALL select the grant by round-robin: if both requesters are valid, grant the priority holder; if only one is valid, grant that one regardless of priority.
REQ-019 SHALL hold reqN_rdy=0 and unit_in_val=0 whenever unit_in_rdy=0 or the FSM is not in IDLE.
REQ-020 SHALL, on a grant, record the owner (0/1) and move to WAIT on the next edge.
REQ-021 SHALL, in WAIT, on unit_out_val=1, capture unit_out_msg into an NBITS result register and move to RESP.
REQ-022 SHALL, in RESP, assert respN_val for the owner only, with respN_msg = result register; the other resp_val SHALL be 0.
REQ-023 SHALL hold respN_val and respN_msg stable in RESP until respN_rdy=1; on that handshake SHALL return to IDLE.
REQ-024 SHALL, on the RESP handshake, set priority to the requester that was not the owner.
REQ-025 SHALL ignore unit_out_val in IDLE and RESP; SHALL ignore respN_rdy outside RESP and from the non-owner.
REQ-026 Latency: grant at cycle T, unit_out_val at T+k, respN_val first high at T+k+1; earliest next grant is the cycle after the RESP handshake.
REQ-027 SHALL drive both respN_msg outputs to 0 when the corresponding respN_val=0.
REQ-028 SHALL allow only one operation outstanding at the unit at any time.

Reset
REQ-029 SHALL, while rst=1, go to IDLE, set priority to requester 0, clear owner and result register, and force all rdy/val outputs and busy to 0.
REQ-030 SHALL abandon any in-flight operation when rst is asserted in WAIT or RESP; no response SHALL be issued for it after reset.
REQ-031 SHALL not grant in the cycle rst is high, even if reqN_val=1 and unit_in_rdy=1.

Verification
REQ-032 Single op: req0_msg=25, unit_out_val pulses with 5 after 4 cycles -> resp0_val=1, resp0_msg=5 one cycle later; resp1_val stays 0.
REQ-033 Contention after reset: req0_msg=10 and req1_msg=20 valid together -> req0 granted first (resp0_msg=2), then req1 (resp1_msg=4); the next simultaneous pair -> req0 granted again, since req1 held priority after req0 and req0 holds priority after req1.
REQ-034 Backpressure: resp1_rdy=0 for 3 cycles in RESP -> resp1_val and resp1_msg stay constant; no new grant until resp1_rdy=1.
REQ-035 Unit not ready: unit_in_rdy=0 with req0_val=1 for 5 cycles -> req0_rdy=0, unit_in_val=0, busy=0; the grant happens in the first cycle unit_in_rdy=1.
REQ-036 Reset mid-op: rst=1 in WAIT, then a unit_out_val pulse -> FSM in IDLE, no resp_val, and the next contended grant goes to req0.
REQ-037 Spurious pulse: unit_out_val=1 in IDLE with msg 7 -> no state change, resp0_val=0 and resp1_val=0.

Source files
------------

// File: rtl/div_by_five_arbiter.sv
// div_by_five_arbiter: round-robin arbiter that lets two requesters share one
// divide-by-five unit, one operation at a time, and returns each result to the
// requester that issued it.
//
// Handshakes: every port pair uses valid/ready. A transfer happens in a cycle
// where valid and ready are both high. A valid source holds its message stable
// until that transfer. unit_out_val is the exception: it is a one-cycle pulse
// with no ready, and the arbiter only listens to it while waiting for a result.
module div_by_five_arbiter #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_val,
    output logic             req0_rdy,
    input  logic [NBITS-1:0] req0_msg,
    input  logic             req1_val,
    output logic             req1_rdy,
    input  logic [NBITS-1:0] req1_msg,

    output logic             resp0_val,
    input  logic             resp0_rdy,
    output logic [NBITS-1:0] resp0_msg,
    output logic             resp1_val,
    input  logic             resp1_rdy,
    output logic [NBITS-1:0] resp1_msg,

    output logic             unit_in_val,
    input  logic             unit_in_rdy,
    output logic [NBITS-1:0] unit_in_msg,
    input  logic             unit_out_val,
    input  logic [NBITS-1:0] unit_out_msg,

    output logic             busy,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;     // requester that wins a tie
    logic             owner_q, owner_d;   // requester whose operation is in flight
    logic [NBITS-1:0] result_q, result_d;

    logic             grant;              // an operand is handed to the unit this cycle
    logic             grant_sel;          // which requester gets it
    logic             owner_rdy;          // owner has taken its result

    // Arbitration: a lone valid requester always wins, a tie goes to prio_q.
    always_comb begin
        grant_sel = 1'b0;
        grant     = 1'b0;
        if (!rst && state_q == S_IDLE && unit_in_rdy && (req0_val || req1_val)) begin
            grant     = 1'b1;
            grant_sel = req1_val && (!req0_val || prio_q);
        end
        owner_rdy = owner_q ? resp1_rdy : resp0_rdy;
    end

    // State register: all flops, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            result_q <= result_d;
        end
    end

    // Next-state logic: grant -> wait for unit pulse -> hold result until taken.
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        owner_d  = owner_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    owner_d = grant_sel;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (unit_out_val) begin
                    result_d = unit_out_msg;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (owner_rdy) begin
                    // Fairness: the other requester wins the next tie.
                    prio_d  = ~owner_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: request side follows the grant, response side follows the owner.
    always_comb begin
        req0_rdy    = grant && !grant_sel;
        req1_rdy    = grant &&  grant_sel;
        unit_in_val = grant;
        unit_in_msg = grant_sel ? req1_msg : req0_msg;
        if (!grant) begin
            unit_in_msg = '0;
        end
        resp0_val   = !rst && state_q == S_RESP && !owner_q;
        resp1_val   = !rst && state_q == S_RESP &&  owner_q;
        resp0_msg   = resp0_val ? result_q : '0;
        resp1_msg   = resp1_val ? result_q : '0;
        busy        = !rst && state_q != S_IDLE;
        state_dbg   = state_q;
    end

endmodule

// File: tb/tb_div_by_five_arbiter.sv
// Directed bench for div_by_five_arbiter. The bench plays the divide-by-five
// unit itself, pulsing unit_out_val with hand-computed quotients.
module tb_div_by_five_arbiter;

    localparam int NBITS = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_val, req0_rdy, req1_val, req1_rdy;
    logic [NBITS-1:0] req0_msg, req1_msg;
    logic             resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic [NBITS-1:0] resp0_msg, resp1_msg;
    logic             unit_in_val, unit_in_rdy, unit_out_val;
    logic [NBITS-1:0] unit_in_msg, unit_out_msg;
    logic             busy;
    logic [1:0]       state_dbg;

    int vectors    = 0;
    int miscompares = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    div_by_five_arbiter #(.NBITS(NBITS)) dut (
        .clk(clk), .rst(rst),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
        .unit_in_val(unit_in_val), .unit_in_rdy(unit_in_rdy), .unit_in_msg(unit_in_msg),
        .unit_out_val(unit_out_val), .unit_out_msg(unit_out_msg),
        .busy(busy), .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample outputs mid-cycle, away from the active edge.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic unit_pulse(input logic [NBITS-1:0] q);
        unit_out_val = 1'b1;
        unit_out_msg = q;
        tick();
        unit_out_val = 1'b0;
        unit_out_msg = '0;
    endtask

    initial begin
        rst = 1'b1;
        req0_val = 1'b1; req0_msg = 8'd33; req1_val = 1'b0; req1_msg = '0;
        resp0_rdy = 1'b0; resp1_rdy = 1'b0;
        unit_in_rdy = 1'b1; unit_out_val = 1'b0; unit_out_msg = '0;

        // Reset: no grant while rst is high, everything quiet.
        tick();
        mid();
        chk("rst_req0_rdy", req0_rdy, 0);
        chk("rst_unit_in_val", unit_in_val, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", state_dbg, ST_IDLE);
        chk("rst_resp_vals", {resp0_val, resp1_val}, 0);
        tick();
        rst = 1'b0; req0_val = 1'b0;

        // Single op: 25 / 5 = 5, result 4 cycles after grant.
        req0_val = 1'b1; req0_msg = 8'd25;
        mid();
        chk("single_req0_rdy", req0_rdy, 1);
        chk("single_req1_rdy", req1_rdy, 0);
        chk("single_unit_in_val", unit_in_val, 1);
        chk("single_unit_in_msg", unit_in_msg, 25);
        tick();
        req0_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("single_wait_state", state_dbg, ST_WAIT);
            chk("single_wait_busy", busy, 1);
            chk("single_wait_resp0_val", resp0_val, 0);
            tick();
        end
        unit_pulse(8'd5);
        mid();
        chk("single_resp0_val", resp0_val, 1);
        chk("single_resp0_msg", resp0_msg, 5);
        chk("single_resp1_val", resp1_val, 0);
        chk("single_resp1_msg", resp1_msg, 0);
        resp1_rdy = 1'b1;                  // non-owner ready is ignored
        tick();
        resp1_rdy = 1'b0;
        mid();
        chk("single_nonowner_rdy_ignored", state_dbg, ST_RESP);
        resp0_rdy = 1'b1;
        tick();
        resp0_rdy = 1'b0;
        mid();
        chk("single_back_idle", state_dbg, ST_IDLE);
        chk("single_resp0_cleared", {resp0_val, resp0_msg}, 0);

        // Contention after reset: req0 first, then req1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_val = 1'b1; req0_msg = 8'd10; req1_val = 1'b1; req1_msg = 8'd20;
        mid();
        chk("cont1_req0_rdy", req0_rdy, 1);
        chk("cont1_req1_rdy", req1_rdy, 0);
        chk("cont1_unit_in_msg", unit_in_msg, 10);
        tick();
        req0_val = 1'b0;
        mid();
        chk("cont1_wait_req1_rdy", req1_rdy, 0);
        chk("cont1_wait_unit_in_val", unit_in_val, 0);
        tick();
        unit_pulse(8'd2);
        mid();
        chk("cont1_resp0_msg", resp0_msg, 2);
        chk("cont1_resp1_val", resp1_val, 0);
        resp0_rdy = 1'b1;
        tick();
        resp0_rdy = 1'b0;
        mid();
        chk("cont2_req1_rdy", req1_rdy, 1);
        chk("cont2_unit_in_msg", unit_in_msg, 20);
        tick();
        req1_val = 1'b0;
        unit_pulse(8'd4);

        // Backpressure on resp1; a waiting req0 must not be granted meanwhile.
        req0_val = 1'b1; req0_msg = 8'd30;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("bp_resp1_val", resp1_val, 1);
            chk("bp_resp1_msg", resp1_msg, 4);
            chk("bp_resp0_val", resp0_val, 0);
            chk("bp_req0_rdy", req0_rdy, 0);
            tick();
        end
        resp1_rdy = 1'b1;
        mid();
        chk("bp_handshake_no_grant", req0_rdy, 0);
        tick();
        resp1_rdy = 1'b0;

        // Next simultaneous pair goes to req0 (priority returned to it).
        req1_val = 1'b1; req1_msg = 8'd40;
        mid();
        chk("cont3_req0_rdy", req0_rdy, 1);
        chk("cont3_req1_rdy", req1_rdy, 0);
        chk("cont3_unit_in_msg", unit_in_msg, 30);
        tick();
        req0_val = 1'b0; req1_val = 1'b0;
        unit_pulse(8'd6);
        mid();
        chk("cont3_resp0_msg", resp0_msg, 6);
        resp0_rdy = 1'b1;
        tick();
        resp0_rdy = 1'b0;

        // Unit not ready: req0 waits, grant in first ready cycle (priority now req1).
        unit_in_rdy = 1'b0;
        req0_val = 1'b1; req0_msg = 8'd50;
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("nrdy_req0_rdy", req0_rdy, 0);
            chk("nrdy_unit_in_val", unit_in_val, 0);
            chk("nrdy_busy", busy, 0);
            tick();
        end
        unit_in_rdy = 1'b1;
        mid();
        chk("nrdy_grant_req0_rdy", req0_rdy, 1);
        chk("nrdy_grant_unit_in_msg", unit_in_msg, 50);
        tick();
        req0_val = 1'b0;
        mid();
        chk("nrdy_wait_state", state_dbg, ST_WAIT);

        // Reset mid-op, then a late unit pulse must be dropped.
        rst = 1'b1;
        mid();
        chk("midrst_busy_forced", busy, 0);
        tick();
        rst = 1'b0;
        mid();
        chk("midrst_state", state_dbg, ST_IDLE);
        tick();
        unit_pulse(8'd10);
        mid();
        chk("midrst_after_pulse_state", state_dbg, ST_IDLE);
        chk("midrst_resp_vals", {resp0_val, resp1_val}, 0);
        req0_val = 1'b1; req0_msg = 8'd55; req1_val = 1'b1; req1_msg = 8'd60;
        #1;
        chk("midrst_cont_req0_rdy", req0_rdy, 1);
        chk("midrst_cont_req1_rdy", req1_rdy, 0);
        req0_val = 1'b0; req1_val = 1'b0;   // withdraw before the edge
        tick();

        // Spurious pulse in IDLE.
        unit_pulse(8'd7);
        mid();
        chk("spur_state", state_dbg, ST_IDLE);
        chk("spur_resp_vals", {resp0_val, resp1_val}, 0);
        chk("spur_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
